// File: rtl/tree_pkg.sv
// Shared types and layout constants for the decision-tree walk sequencer,
// its node-memory loader and the accelerator top level.
package tree_pkg;

  localparam int NCOEF_DEF     = 3;
  localparam int ATTR_W_DEF    = 8;
  localparam int COEF_W_DEF    = 8;
  localparam int THR_W_DEF     = 10;
  localparam int ACC_W_DEF     = 16;
  localparam int ADDR_W_DEF    = 8;
  localparam int CLASS_W_DEF   = 8;
  localparam int ROOT_ADDR_DEF = 0;
  localparam int MAX_DEPTH_DEF = 16;

  // Node word = {coef[0], ..., coef[NCOEF-1], thr}; child word = {left, right},
  // each child entry = {leaf, payload}.
  localparam int NODE_THR_LSB       = 0;
  localparam int NODE_COEF_LSB_DEF  = THR_W_DEF;
  localparam int NODE_W_DEF         = NCOEF_DEF * COEF_W_DEF + THR_W_DEF;
  localparam int CHILD_ENTRY_W_DEF  = ADDR_W_DEF + 1;
  localparam int CHILD_LEAF_BIT_DEF = ADDR_W_DEF;
  localparam int CHILD_RIGHT_LSB    = 0;
  localparam int CHILD_LEFT_LSB_DEF = CHILD_ENTRY_W_DEF;
  localparam int CHILD_W_DEF        = 2 * CHILD_ENTRY_W_DEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_MAC,
    S_ACC,
    S_DECIDE,
    S_DONE
  } walk_state_e;

endpackage

// File: rtl/tree_walk_ctrl_node_sel.sv
// Threshold compare and child selection for one tree node: an accumulated
// sum at or below the threshold takes the left child, above it the right.
module tree_node_sel #(
  parameter int ACC_W  = 16,
  parameter int THR_W  = 10,
  parameter int ADDR_W = 8
) (
  input  logic [ACC_W-1:0]        mac_acc_i,
  input  logic [THR_W-1:0]        thr_i,
  input  logic [2*(ADDR_W+1)-1:0] child_i,
  output logic                    leaf_o,
  output logic [ADDR_W-1:0]       payload_o
);

  localparam int CMP_W = (ACC_W > THR_W) ? ACC_W : THR_W;
  localparam int ENT_W = ADDR_W + 1;

  logic             take_left;
  logic [ENT_W-1:0] entry;

  assign take_left = CMP_W'(mac_acc_i) <= CMP_W'(thr_i);
  assign entry     = take_left ? child_i[ENT_W +: ENT_W] : child_i[0 +: ENT_W];
  assign leaf_o    = entry[ADDR_W];
  assign payload_o = entry[ADDR_W-1:0];

endmodule

// File: rtl/tree_walk_ctrl.sv
// Walks one decision tree per request: fetch node, run the shared MAC over
// the latched attributes, compare against the node threshold, follow a child.
//   state  | meaning
//   IDLE   | waiting for start
//   FETCH  | node read strobe, accumulator clear
//   LOAD   | capture node and child words
//   MAC    | NCOEF multiply-accumulate cycles
//   ACC    | wait for final product to land in the accumulator
//   DECIDE | pick child; finish on leaf or depth limit
//   DONE   | one-cycle completion pulse
module tree_walk_ctrl
  import tree_pkg::*;
#(
  parameter int NCOEF     = NCOEF_DEF,
  parameter int ATTR_W    = ATTR_W_DEF,
  parameter int COEF_W    = COEF_W_DEF,
  parameter int THR_W     = THR_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int CLASS_W   = CLASS_W_DEF,
  parameter int ROOT_ADDR = ROOT_ADDR_DEF,
  parameter int MAX_DEPTH = MAX_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NCOEF*ATTR_W-1:0]     attr_vec,
  output logic                        busy,
  output logic                        done,
  output logic [CLASS_W-1:0]          out_class,
  output logic                        err_depth,
  output logic [ADDR_W-1:0]           node_addr,
  output logic                        node_rd_en,
  input  logic [NCOEF*COEF_W+THR_W-1:0] node_rdata,
  input  logic [2*(ADDR_W+1)-1:0]     child_rdata,
  output logic                        mac_clr,
  output logic                        mac_en,
  output logic [ATTR_W-1:0]           mac_a,
  output logic [COEF_W-1:0]           mac_b,
  input  logic [ACC_W-1:0]            mac_acc
);

  localparam int K_W     = (NCOEF > 1) ? $clog2(NCOEF) : 1;
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
  localparam int CHILD_W = 2 * (ADDR_W + 1);

  walk_state_e        state_q, state_d;
  logic [ATTR_W-1:0]  attr_q [NCOEF];
  logic [ATTR_W-1:0]  attr_d [NCOEF];
  logic [COEF_W-1:0]  coef_q [NCOEF];
  logic [COEF_W-1:0]  coef_d [NCOEF];
  logic [THR_W-1:0]   thr_q, thr_d;
  logic [CHILD_W-1:0] child_q, child_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [CLASS_W-1:0] out_class_q, out_class_d;
  logic               err_depth_q, err_depth_d;
  logic               sel_leaf;
  logic [ADDR_W-1:0]  sel_payload;

  tree_node_sel #(
    .ACC_W  (ACC_W),
    .THR_W  (THR_W),
    .ADDR_W (ADDR_W)
  ) u_node_sel (
    .mac_acc_i (mac_acc),
    .thr_i     (thr_q),
    .child_i   (child_q),
    .leaf_o    (sel_leaf),
    .payload_o (sel_payload)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      thr_q       <= '0;
      child_q     <= '0;
      cur_addr_q  <= '0;
      depth_q     <= '0;
      k_q         <= '0;
      out_class_q <= '0;
      err_depth_q <= 1'b0;
      for (int i = 0; i < NCOEF; i++) begin
        attr_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      thr_q       <= thr_d;
      child_q     <= child_d;
      cur_addr_q  <= cur_addr_d;
      depth_q     <= depth_d;
      k_q         <= k_d;
      out_class_q <= out_class_d;
      err_depth_q <= err_depth_d;
      attr_q      <= attr_d;
      coef_q      <= coef_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    attr_d      = attr_q;
    coef_d      = coef_q;
    thr_d       = thr_q;
    child_d     = child_q;
    cur_addr_d  = cur_addr_q;
    depth_d     = depth_q;
    k_d         = k_q;
    out_class_d = out_class_q;
    err_depth_d = err_depth_q;
    done        = 1'b0;
    node_rd_en  = 1'b0;
    node_addr   = '0;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    mac_a       = '0;
    mac_b       = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < NCOEF; i++)
            attr_d[i] = attr_vec[(NCOEF-1-i)*ATTR_W +: ATTR_W];
          cur_addr_d  = ADDR_W'(ROOT_ADDR);
          depth_d     = '0;
          out_class_d = '0;
          err_depth_d = 1'b0;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        node_rd_en = 1'b1;
        node_addr  = cur_addr_q;
        mac_clr    = 1'b1;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        for (int i = 0; i < NCOEF; i++)
          coef_d[i] = node_rdata[THR_W + (NCOEF-1-i)*COEF_W +: COEF_W];
        thr_d   = node_rdata[NODE_THR_LSB +: THR_W];
        child_d = child_rdata;
        k_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        mac_en = 1'b1;
        mac_a  = attr_q[k_q];
        mac_b  = coef_q[k_q];
        if (k_q == K_W'(NCOEF - 1)) state_d = S_ACC;
        else                        k_d     = k_q + 1'b1;
      end
      S_ACC: state_d = S_DECIDE;
      S_DECIDE: begin
        if (sel_leaf) begin
          out_class_d = sel_payload[CLASS_W-1:0];
          state_d     = S_DONE;
        end else if (depth_q == DEPTH_W'(MAX_DEPTH - 1)) begin
          // Depth limit also catches self-loops and cycles in a corrupt tree.
          err_depth_d = 1'b1;
          out_class_d = '0;
          state_d     = S_DONE;
        end else begin
          cur_addr_d = sel_payload;
          depth_d    = depth_q + 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign out_class = out_class_q;
  assign err_depth = err_depth_q;

endmodule

// File: doc/tree_walk_ctrl.md
# tree_walk_ctrl

Sequencer for the decision-tree accelerator datapath. Starting at the root, it walks one tree per request. At each node it reads the coefficient/threshold word and the child-pointer word, drives the shared multiply-accumulate unit with the latched attribute vector, and compares the accumulated sum against the node threshold. It then follows the left or right child until a leaf flag is found and returns the class. It sits between the host request interface and the node memories plus MAC, and replaces ad-hoc counter sequencing in the top level.

## Interface
- NCOEF, 3, coefficients (and attributes) per node
- ATTR_W, 8, attribute width
- COEF_W, 8, coefficient width
- THR_W, 10, threshold width
- ACC_W, 16, MAC accumulator width
- ADDR_W, 8, node address width
- CLASS_W, 8, class width (≤ ADDR_W)
- ROOT_ADDR, 0, root node address
- MAX_DEPTH, 16, maximum internal nodes visited before abort

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- attr_vec  in  NCOEF*ATTR_W  attributes; attr[0] in MSBs; latched on accepted start
- busy  out  1  high from accepted start through the DONE state
- done  out  1  one-cycle completion pulse
- out_class  out  CLASS_W  class result; held until next accepted start
- err_depth  out  1  set with done when MAX_DEPTH is exceeded; held like out_class
- node_addr  out  ADDR_W  shared address to both node memories
- node_rd_en  out  1  read strobe; registered memory data valid the following cycle
- node_rdata  in  NCOEF*COEF_W+THR_W  coef[0] in MSBs, threshold in LSBs
- child_rdata  in  2*(ADDR_W+1)  left entry in upper half; each entry is {leaf, ADDR_W payload}
- mac_clr  out  1  clears accumulator (acc = 0 next cycle)
- mac_en  out  1  acc <= acc + mac_a*mac_b next cycle
- mac_a  out  ATTR_W  attribute operand
- mac_b  out  COEF_W  coefficient operand
- mac_acc  in  ACC_W  accumulator value, unsigned

## Operation
- States: IDLE, FETCH, LOAD, MAC, ACC, DECIDE, DONE.
- IDLE → FETCH on start.
  - Latch attr_vec, set cur_addr = ROOT_ADDR and depth = 0.
  - Clear out_class and err_depth.
- FETCH → LOAD: node_rd_en = 1, node_addr = cur_addr, mac_clr = 1.
- LOAD → MAC: capture node_rdata and child_rdata into local registers; k = 0.
- MAC, NCOEF cycles:
  - mac_en = 1, mac_a = attr[k], mac_b = coef[k].
  - k increments; after k = NCOEF-1, go to ACC.
- ACC → DECIDE: single wait cycle so mac_acc reflects the final product.
- DECIDE:
  - If mac_acc ≤ zero-extended threshold, select the left entry; otherwise select the right entry. The compare is unsigned.
  - If selected leaf = 1: out_class = payload[CLASS_W-1:0], then go to DONE.
  - If leaf = 0 and depth+1 = MAX_DEPTH: err_depth = 1, out_class = 0, then go to DONE.
  - Otherwise: cur_addr = payload, depth++, then go to FETCH.
- DONE → IDLE: done = 1 for exactly one cycle; busy still high.
- start outside IDLE is ignored and not queued.
- mac_a, mac_b, node_addr = 0 whenever their enables are low.
- Child payload equal to cur_addr (self-loop) is not special-cased; MAX_DEPTH terminates it.

## Timing
- Reset values:
  - busy, done, err_depth, node_rd_en, mac_en, mac_clr = 0.
  - out_class, node_addr, mac_a, mac_b = 0.
  - State = IDLE.
- rst mid-walk: returns to IDLE next cycle with all outputs at reset values; no done pulse.
- Per internal node: NCOEF+4 cycles (7 at defaults).
- Start accepted in cycle 0 → FETCH in cycle 1 → done high in cycle 1 + d·(NCOEF+4), where d = internal nodes visited. At defaults: d=1 gives cycle 8, d=3 gives cycle 22.
- Back-to-back: start may be accepted the cycle after done (IDLE).
- Memories must have exactly 1-cycle read latency; MAC must update acc 1 cycle after mac_en or mac_clr. mac_clr and mac_en are never asserted together.

## Structure
- Shared package tree_pkg holds:
  - state enum;
  - default width constants;
  - node-word and child-entry field offset constants, shared with the loader and top level.
- Sub-module tree_node_sel: combinational compare plus child select, outputs {leaf, payload}. Everything else lives in tree_walk_ctrl.

## Test plan
- Single-leaf tree:
  - Stimulus: root coef = {1,2,3}, thr = 20, attr = {2,3,4} (acc = 20), left = {1, 0x05}.
  - Required: done at cycle 8, out_class = 0x05, mac_acc compared = 20.
- Same tree with thr = 19:
  - Stimulus: right = {1, 0x0A}.
  - Required: out_class = 0x0A (strict > takes right).
- Depth-3 walk:
  - Stimulus: node 0 → 4 → 9 → leaf class 0x33.
  - Required: node_addr sequence 0, 4, 9 on FETCH cycles; done at cycle 22; busy high cycles 1–22.
- Self-loop:
  - Stimulus: node 2 child = {0, 2}, MAX_DEPTH = 16.
  - Required: done with err_depth = 1, out_class = 0 after 16 fetches.
- Stimulus: start pulses during busy.
  - Required: ignored, no extra fetch.
  - Stimulus: rst asserted in MAC state.
  - Required: next cycle IDLE, all outputs 0, no done; subsequent start walks correctly.
- Overflow/max:
  - Stimulus: attr = coef = all 0xFF, thr = 0x3FF.
  - Required: acc = 195075 mod 2^16 = 0xFA03 > 0x3FF, so right child taken.
